wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_pkg.sv | 27 ++
 rtl/wb_fifo.sv | 65 ++++++
 rtl/wb_arbiter.sv | 156 +++++++++++++++
 tb/tb_wb_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared types and constants for the write-back arbiter.
//   REG_COUNT  : number of architectural registers (x0..x31)
//   XLEN       : datapath width
//   RD_W       : register index width
//   wb_entry_t : buffered MDU result {rd, data}
//   rd_onehot  : register index -> one-hot register mask
// -----------------------------------------------------------------------------
package wb_pkg;

    localparam int REG_COUNT = 32;
    localparam int XLEN      = 64;
    localparam int RD_W      = 5;

    typedef struct packed {
        logic [RD_W-1:0] rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

    function automatic logic [REG_COUNT-1:0] rd_onehot(input logic [RD_W-1:0] rd);
        logic [REG_COUNT-1:0] one;
        one = {{(REG_COUNT-1){1'b0}}, 1'b1};
        return one << rd;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// In-order buffer for MDU results awaiting the register-file write port.
// Storage is an array without reset; only pointers and count are cleared, so a
// reset empties the buffer and discards anything held in it.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   i_push, i_entry : enqueue request and payload (ignored when full)
//   i_pop           : dequeue request (ignored when empty)
//   o_head          : entry at the read pointer (valid while !o_empty)
//   o_full, o_empty : occupancy flags
// Parameter DEPTH must be a power of two (>= 2) so pointers wrap naturally.
// -----------------------------------------------------------------------------
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_push,
    input  wb_entry_t i_entry,
    input  logic      i_pop,
    output wb_entry_t o_head,
    output logic      o_full,
    output logic      o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_entry;
    end

endmodule

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
// Shares one register-file write port between the ALU (no backpressure) and a
// buffered MDU result stream, and tracks which registers have an MDU write
// outstanding.
// Ports:
//   clk, rst_n                    : clock, synchronous active-low reset
//   aluValid, aluRd, aluData      : ALU result this cycle
//   aluStall                      : upstream must hold the ALU result
//   mduValid, mduReady            : MDU result handshake (ready = buffer not full)
//   mduRd, mduData                : MDU result
//   issueValid, issueRd           : MDU op issued, marks issueRd pending
//   regWrite, writeReg, dataWrite : registered write port (one cycle per write)
//   pendingMask                   : bit i set while an MDU write to xi is outstanding
// Build option: define WB_STARVE_GUARD_EN to enable the starvation guard that
// forces the buffer head out after STARVE_LIMIT full-buffer cycles lost to the
// ALU. Without it aluStall is tied low and the ALU always wins.
// -----------------------------------------------------------------------------
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 aluValid,
    input  logic [RD_W-1:0]      aluRd,
    input  logic [XLEN-1:0]      aluData,
    input  logic                 mduValid,
    output logic                 mduReady,
    input  logic [RD_W-1:0]      mduRd,
    input  logic [XLEN-1:0]      mduData,
    input  logic                 issueValid,
    input  logic [RD_W-1:0]      issueRd,
    output logic                 regWrite,
    output logic [RD_W-1:0]      writeReg,
    output logic [XLEN-1:0]      dataWrite,
    output logic [REG_COUNT-1:0] pendingMask,
    output logic                 aluStall
);

    wb_entry_t w_mdu_entry;
    wb_entry_t w_head;
    logic      w_full;
    logic      w_empty;
    logic      w_push;
    logic      w_pop;
    logic      w_stall;
    logic      w_alu_win;

    logic                 w_sel_we;
    logic [RD_W-1:0]      w_sel_rd;
    logic [XLEN-1:0]      w_sel_data;
    logic [REG_COUNT-1:0] w_set_vec;
    logic [REG_COUNT-1:0] w_clr_vec;
    logic [REG_COUNT-1:0] w_pending_next;

    logic                 r_reg_write;
    logic [RD_W-1:0]      r_write_reg;
    logic [XLEN-1:0]      r_data_write;
    logic [REG_COUNT-1:0] r_pending;

    assign w_mdu_entry.rd   = mduRd;
    assign w_mdu_entry.data = mduData;

    // Ready depends only on occupancy, so a full buffer never accepts even if
    // it pops in the same cycle.
    assign mduReady  = !w_full;
    assign w_push    = mduValid && mduReady;
    assign w_alu_win = aluValid && !w_stall;
    assign w_pop     = !w_alu_win && !w_empty;
    assign aluStall  = w_stall;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_entry (w_mdu_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

`ifdef WB_STARVE_GUARD_EN
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic [STARVE_W-1:0] r_starve_cnt;

    assign w_stall = (r_starve_cnt == STARVE_W'(STARVE_LIMIT));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
        end else if (w_pop) begin
            r_starve_cnt <= '0;
        end else if (w_full && w_alu_win && !w_stall) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end
`else
    assign w_stall = 1'b0;
`endif

    // Source selection; rd==0 consumes the slot but produces no write.
    always_comb begin
        w_sel_we   = 1'b0;
        w_sel_rd   = '0;
        w_sel_data = '0;
        if (w_alu_win) begin
            w_sel_we   = (aluRd != '0);
            w_sel_rd   = aluRd;
            w_sel_data = aluData;
        end else if (w_pop) begin
            w_sel_we   = (w_head.rd != '0);
            w_sel_rd   = w_head.rd;
            w_sel_data = w_head.data;
        end
    end

    // Pending scoreboard: an issue in the same cycle as the matching pop keeps
    // the bit set, since a newer MDU write is now outstanding. x0 never pends.
    assign w_set_vec = issueValid ? rd_onehot(issueRd) : '0;
    assign w_clr_vec = w_pop ? rd_onehot(w_head.rd) : '0;

    for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_pend
        if (gi == 0) begin : g_x0
            assign w_pending_next[gi] = 1'b0;
        end else begin : g_xn
            assign w_pending_next[gi] = w_set_vec[gi] | (r_pending[gi] & ~w_clr_vec[gi]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_reg_write  <= 1'b0;
            r_write_reg  <= '0;
            r_data_write <= '0;
            r_pending    <= '0;
        end else begin
            r_reg_write  <= w_sel_we;
            r_write_reg  <= w_sel_rd;
            r_data_write <= w_sel_data;
            r_pending    <= w_pending_next;
        end
    end

    assign regWrite    = r_reg_write;
    assign writeReg    = r_write_reg;
    assign dataWrite   = r_data_write;
    assign pendingMask = r_pending;

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
// Self-checking bench for wb_arbiter: table of single-cycle ALU writes, then
// hand-written multi-cycle sequences. Every expected write is queued when the
// cycle that selects it is driven; a monitor pops and compares each regWrite.
// Define WB_STARVE_GUARD_EN for both RTL and bench to exercise the guard.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;
    import wb_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 aluValid;
    logic [RD_W-1:0]      aluRd;
    logic [XLEN-1:0]      aluData;
    logic                 mduValid;
    logic                 mduReady;
    logic [RD_W-1:0]      mduRd;
    logic [XLEN-1:0]      mduData;
    logic                 issueValid;
    logic [RD_W-1:0]      issueRd;
    logic                 regWrite;
    logic [RD_W-1:0]      writeReg;
    logic [XLEN-1:0]      dataWrite;
    logic [REG_COUNT-1:0] pendingMask;
    logic                 aluStall;

    always #5 clk = ~clk;

    wb_arbiter #(
        .FIFO_DEPTH   (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .aluValid    (aluValid),
        .aluRd       (aluRd),
        .aluData     (aluData),
        .mduValid    (mduValid),
        .mduReady    (mduReady),
        .mduRd       (mduRd),
        .mduData     (mduData),
        .issueValid  (issueValid),
        .issueRd     (issueRd),
        .regWrite    (regWrite),
        .writeReg    (writeReg),
        .dataWrite   (dataWrite),
        .pendingMask (pendingMask),
        .aluStall    (aluStall)
    );

    int n_pass  = 0;
    int n_total = 0;

    wb_entry_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic sb_push(input logic [RD_W-1:0] rd, input logic [XLEN-1:0] d);
        wb_entry_t e;
        e.rd   = rd;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every write on the port must match the queue head.
    always @(posedge clk) begin
        wb_entry_t e;
        #4;
        if (regWrite === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_write", {59'd0, writeReg}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("sb_rd", {59'd0, writeReg}, {59'd0, e.rd});
                chk("sb_data", dataWrite, e.data);
                $display("write x%0d = 0x%0h", writeReg, dataWrite);
            end
        end
    end

    typedef struct {
        logic            alu_v;
        logic [RD_W-1:0] rd;
        logic [XLEN-1:0] data;
        logic            exp_we;
        logic [RD_W-1:0] exp_rd;
        logic [XLEN-1:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{1'b1, 5'd5,  64'h1234,                1'b1, 5'd5,  64'h1234};
        vecs[1] = '{1'b0, 5'd0,  64'h0,                   1'b0, 5'd0,  64'h0};
        vecs[2] = '{1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[3] = '{1'b1, 5'd0,  64'hDEAD,                1'b0, 5'd0,  64'h0};
        vecs[4] = '{1'b1, 5'd1,  64'h8000_0000_0000_0001, 1'b1, 5'd1,  64'h8000_0000_0000_0001};
        vecs[5] = '{1'b0, 5'd9,  64'h5555,                1'b0, 5'd0,  64'h0};

        rst_n = 1'b0; aluValid = 1'b0; aluRd = '0; aluData = '0;
        mduValid = 1'b0; mduRd = '0; mduData = '0; issueValid = 1'b0; issueRd = '0;

        // ---------------- reset state ----------------
        tick(); tick();
        chk("rst_regWrite", {63'd0, regWrite}, 64'd0);
        chk("rst_writeReg", {59'd0, writeReg}, 64'd0);
        chk("rst_dataWrite", dataWrite, 64'd0);
        chk("rst_pendingMask", {32'd0, pendingMask}, 64'd0);
        chk("rst_mduReady", {63'd0, mduReady}, 64'd1);
        chk("rst_aluStall", {63'd0, aluStall}, 64'd0);
        rst_n = 1'b1;

        // ---------------- table: single ALU writes ----------------
        for (int i = 0; i < 6; i++) begin
            aluValid = vecs[i].alu_v;
            aluRd    = vecs[i].rd;
            aluData  = vecs[i].data;
            if (vecs[i].exp_we) sb_push(vecs[i].exp_rd, vecs[i].exp_data);
            tick();
            chk($sformatf("vec%0d_we", i), {63'd0, regWrite}, {63'd0, vecs[i].exp_we});
            if (vecs[i].exp_we) begin
                chk($sformatf("vec%0d_rd", i), {59'd0, writeReg}, {59'd0, vecs[i].exp_rd});
                chk($sformatf("vec%0d_data", i), dataWrite, vecs[i].exp_data);
            end
        end
        aluValid = 1'b0;

        // ---------------- pending bit set/clear (x7) ----------------
        issueValid = 1'b1; issueRd = 5'd7;
        tick();
        issueValid = 1'b0;
        chk("pend_set7", {32'd0, pendingMask}, 64'h80);
        mduValid = 1'b1; mduRd = 5'd7; mduData = 64'hAA;
        #1 chk("rdy_empty", {63'd0, mduReady}, 64'd1);
        tick();
        mduValid = 1'b0;
        sb_push(5'd7, 64'hAA);
        chk("pend_hold7", {32'd0, pendingMask}, 64'h80);
        chk("we_before_pop", {63'd0, regWrite}, 64'd0);
        tick();
        chk("mdu_we7", {63'd0, regWrite}, 64'd1);
        chk("mdu_rd7", {59'd0, writeReg}, 64'd7);
        chk("mdu_data7", dataWrite, 64'hAA);
        chk("pend_clr7", {32'd0, pendingMask}, 64'h0);
        tick();
        chk("mdu_we_once", {63'd0, regWrite}, 64'd0);

        // ---------------- set wins over clear (x9) ----------------
        issueValid = 1'b1; issueRd = 5'd9;
        tick();
        issueValid = 1'b0;
        mduValid = 1'b1; mduRd = 5'd9; mduData = 64'h99;
        tick();
        mduValid = 1'b0;
        issueValid = 1'b1; issueRd = 5'd9;
        sb_push(5'd9, 64'h99);
        tick();
        issueValid = 1'b0;
        chk("setwins_pend", {32'd0, pendingMask}, 64'h200);
        chk("setwins_we", {63'd0, regWrite}, 64'd1);
        tick();
        chk("setwins_hold", {32'd0, pendingMask}, 64'h200);
        mduValid = 1'b1; mduRd = 5'd9; mduData = 64'h199;
        tick();
        mduValid = 1'b0;
        sb_push(5'd9, 64'h199);
        tick();
        chk("setwins_clr", {32'd0, pendingMask}, 64'h0);

        // ---------------- back-to-back MDU under ALU traffic ----------------
        aluValid = 1'b1; aluRd = 5'd10; aluData = 64'h1000;
        mduValid = 1'b1; mduRd = 5'd20; mduData = 64'h20;
        sb_push(5'd10, 64'h1000);
        #1 chk("bb_rdy0", {63'd0, mduReady}, 64'd1);
        tick();
        aluRd = 5'd11; aluData = 64'h1001; mduRd = 5'd21; mduData = 64'h21;
        sb_push(5'd11, 64'h1001);
        #1 chk("bb_rdy1", {63'd0, mduReady}, 64'd1);
        tick();
        aluRd = 5'd12; aluData = 64'h1002; mduRd = 5'd22; mduData = 64'h22;
        sb_push(5'd12, 64'h1002);
        #1 chk("bb_rdy2_full", {63'd0, mduReady}, 64'd0);
        tick();
        aluValid = 1'b0;
        sb_push(5'd20, 64'h20);
        #1 chk("bb_rdy3_full", {63'd0, mduReady}, 64'd0);
        tick();
        sb_push(5'd21, 64'h21);
        #1 chk("bb_rdy4", {63'd0, mduReady}, 64'd1);
        tick();
        mduValid = 1'b0;
        sb_push(5'd22, 64'h22);
        tick();
        chk("bb_last_rd", {59'd0, writeReg}, 64'd22);
        tick();
        chk("bb_idle_we", {63'd0, regWrite}, 64'd0);

        // ---------------- rd==0 MDU entry ----------------
        aluValid = 1'b1; aluRd = 5'd3; aluData = 64'h3;
        mduValid = 1'b1; mduRd = 5'd0; mduData = 64'h55;
        sb_push(5'd3, 64'h3);
        tick();
        aluRd = 5'd5; aluData = 64'h5; mduRd = 5'd4; mduData = 64'h44;
        sb_push(5'd5, 64'h5);
        tick();
        mduValid = 1'b0; aluRd = 5'd6; aluData = 64'h6;
        sb_push(5'd6, 64'h6);
        #1 chk("rd0_full", {63'd0, mduReady}, 64'd0);
        tick();
        aluValid = 1'b0;
        tick();
        chk("rd0_pop_we", {63'd0, regWrite}, 64'd0);
        chk("rd0_count_dec", {63'd0, mduReady}, 64'd1);
        sb_push(5'd4, 64'h44);
        tick();
        chk("rd0_next_rd", {59'd0, writeReg}, 64'd4);
        tick();

        // ---------------- starvation guard ----------------
        aluValid = 1'b1; aluRd = 5'd13; aluData = 64'hD0;
        mduValid = 1'b1; mduRd = 5'd11; mduData = 64'hB1;
        sb_push(5'd13, 64'hD0);
        tick();
        aluRd = 5'd14; aluData = 64'hD1; mduRd = 5'd12; mduData = 64'hB2;
        sb_push(5'd14, 64'hD1);
        tick();
        mduValid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            aluRd = 5'(15 + k); aluData = 64'(16'hE0 + k);
            sb_push(aluRd, aluData);
            #1 chk($sformatf("starve_nostall%0d", k), {63'd0, aluStall}, 64'd0);
            tick();
        end
        aluRd = 5'd19; aluData = 64'h19;
`ifdef WB_STARVE_GUARD_EN
        sb_push(5'd11, 64'hB1);
        #1 chk("starve_stall", {63'd0, aluStall}, 64'd1);
        tick();
        chk("starve_mdu_rd", {59'd0, writeReg}, 64'd11);
        sb_push(5'd19, 64'h19);
        #1 chk("starve_release", {63'd0, aluStall}, 64'd0);
        tick();
        aluValid = 1'b0;
        sb_push(5'd12, 64'hB2);
        tick();
`else
        sb_push(5'd19, 64'h19);
        #1 chk("starve_off_stall", {63'd0, aluStall}, 64'd0);
        tick();
        chk("starve_off_alu_rd", {59'd0, writeReg}, 64'd19);
        aluValid = 1'b0;
        sb_push(5'd11, 64'hB1);
        tick();
        sb_push(5'd12, 64'hB2);
        tick();
`endif
        tick();

        // ---------------- reset mid-operation ----------------
        issueValid = 1'b1; issueRd = 5'd14;
        tick();
        issueRd = 5'd15;
        tick();
        issueValid = 1'b0;
        aluValid = 1'b1; aluRd = 5'd20; aluData = 64'h200;
        mduValid = 1'b1; mduRd = 5'd14; mduData = 64'h14;
        sb_push(5'd20, 64'h200);
        tick();
        aluRd = 5'd21; aluData = 64'h201; mduRd = 5'd15; mduData = 64'h15;
        sb_push(5'd21, 64'h201);
        tick();
        mduValid = 1'b0;
        chk("prerst_pend", {32'd0, pendingMask}, 64'hC000);
        chk("prerst_full", {63'd0, mduReady}, 64'd0);
        aluRd = 5'd22; aluData = 64'h202;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        aluValid = 1'b0;
        chk("midrst_we", {63'd0, regWrite}, 64'd0);
        chk("midrst_pend", {32'd0, pendingMask}, 64'h0);
        chk("midrst_rdy", {63'd0, mduReady}, 64'd1);
        chk("midrst_stall", {63'd0, aluStall}, 64'd0);
        tick();
        chk("postrst_we0", {63'd0, regWrite}, 64'd0);
        tick();
        chk("postrst_we1", {63'd0, regWrite}, 64'd0);
        tick();
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
